// File: rtl/array_2d_ram_ctrl_if.sv
// array_2d_ram_ctrl_if: clear, write and multi-port read bundle for the 2D array controller
interface array_2d_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int NUM_RD = 2
);
  logic                     clr_start;
  logic                     clr_busy;
  logic                     wr_en;
  logic [ROW_W-1:0]         wr_row;
  logic [COL_W-1:0]         wr_col;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_err;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ROW_W-1:0]  rd_row;
  logic [NUM_RD*COL_W-1:0]  rd_col;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_err;
  modport master (
    output clr_start, wr_en, wr_row, wr_col, wr_data, rd_en, rd_row, rd_col,
    input  clr_busy, wr_err, rd_data, rd_valid, rd_err
  );
  modport slave (
    input  clr_start, wr_en, wr_row, wr_col, wr_data, rd_en, rd_row, rd_col,
    output clr_busy, wr_err, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/array_2d_ram_ctrl.sv
// array_2d_ram_ctrl: ROWS x COLS array, one write port, NUM_RD registered read ports, zeroing sweep
module array_2d_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int NUM_RD = 2
) (
  input logic                clk,
  input logic                rst,
  array_2d_ram_ctrl_if.slave bus
);
  localparam int N = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam logic [ROW_W:0] ROW_LIM = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0] COL_LIM = (COL_W+1)'(COLS);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [DATA_W-1:0] mem [N];
  logic wr_ok;
  logic [IDX_W-1:0] wr_addr;
  logic [NUM_RD-1:0] rd_ok;
  logic [IDX_W-1:0] rd_addr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0] rd_valid_q, rd_err_q;
  logic wr_err_q;

  function automatic logic hit(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return ({1'b0, r} < ROW_LIM) && ({1'b0, c} < COL_LIM);
  endfunction

  function automatic logic [IDX_W-1:0] lin(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return IDX_W'(32'(r) * COLS + 32'(c));
  endfunction

  always_comb begin
    wr_ok = bus.wr_en && state == IDLE && hit(bus.wr_row, bus.wr_col);
    wr_addr = lin(bus.wr_row, bus.wr_col);
    for (int p = 0; p < NUM_RD; p++) begin
      rd_ok[p] = hit(bus.rd_row[p*ROW_W +: ROW_W], bus.rd_col[p*COL_W +: COL_W]);
      rd_addr[p] = lin(bus.rd_row[p*ROW_W +: ROW_W], bus.rd_col[p*COL_W +: COL_W]);
    end
  end

  // idx stays at 0 outside the sweep, so a new sweep always starts at entry 0
  always_comb begin
    state_nxt = (state == IDLE) ? (bus.clr_start ? CLEAR : IDLE)
                                : (idx == IDX_W'(N-1) ? IDLE : CLEAR);
    idx_nxt = (state == CLEAR && idx != IDX_W'(N-1)) ? idx + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      wr_err_q <= bus.wr_en && !wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[idx] <= '0;
    else if (wr_ok) mem[wr_addr] <= bus.wr_data;
  end

  // read data samples the pre-edge contents, giving read-before-write ordering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_valid_q <= '0;
      rd_err_q <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++)
        if (bus.rd_en[p]) rd_data_q[p*DATA_W +: DATA_W] <= rd_ok[p] ? mem[rd_addr[p]] : '0;
      rd_valid_q <= bus.rd_en;
      rd_err_q <= bus.rd_en & ~rd_ok;
    end
  end

  assign bus.clr_busy = state == CLEAR;
  assign bus.wr_err = wr_err_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err = rd_err_q;
endmodule

// File: tb/tb_array_2d_ram_ctrl.sv
// tb_array_2d_ram_ctrl: random and directed stimulus checked against an array-level reference model
module tb_array_2d_ram_ctrl;
  localparam int DW = 8, ROWS = 10, COLS = 6, RW = 4, CW = 3, NR = 3, N = ROWS * COLS;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  array_2d_ram_ctrl_if #(.DATA_W(DW), .ROW_W(RW), .COL_W(CW), .NUM_RD(NR)) bus ();
  array_2d_ram_ctrl #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(RW), .COL_W(CW), .NUM_RD(NR))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] m_mem [N];
  bit m_known [N];
  bit m_busy;
  int m_idx;
  logic exp_busy, exp_wr_err;
  logic [NR-1:0] exp_valid, exp_err;
  logic [DW-1:0] exp_data [NR];
  bit exp_known [NR];
  int vectors = 0, miscompares = 0;
  bit chk = 0;

  function automatic bit inr(int r, int c);
    return r < ROWS && c < COLS;
  endfunction

  function automatic logic [DW-1:0] fd(int i, int seed);
    return DW'(i + seed + 1);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference model: array contents plus a sweep pointer, advanced once per clock
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_idx = 0;
      exp_busy = 0;
      exp_wr_err = 0;
      exp_valid = '0;
      exp_err = '0;
      for (int p = 0; p < NR; p++) begin
        exp_data[p] = '0;
        exp_known[p] = 1;
      end
    end else begin
      for (int p = 0; p < NR; p++) begin
        automatic int r = int'(bus.rd_row[p*RW +: RW]);
        automatic int c = int'(bus.rd_col[p*CW +: CW]);
        exp_valid[p] = bus.rd_en[p];
        exp_err[p] = bus.rd_en[p] && !inr(r, c);
        if (bus.rd_en[p]) begin
          if (inr(r, c)) begin
            exp_data[p] = m_mem[r*COLS + c];
            exp_known[p] = m_known[r*COLS + c];
          end else begin
            exp_data[p] = '0;
            exp_known[p] = 1;
          end
        end
      end
      exp_wr_err = bus.wr_en && (m_busy || !inr(int'(bus.wr_row), int'(bus.wr_col)));
      if (bus.wr_en && !exp_wr_err) begin
        m_mem[int'(bus.wr_row)*COLS + int'(bus.wr_col)] = bus.wr_data;
        m_known[int'(bus.wr_row)*COLS + int'(bus.wr_col)] = 1;
      end
      if (m_busy) begin
        m_mem[m_idx] = '0;
        m_known[m_idx] = 1;
        m_idx++;
        if (m_idx == N) begin
          m_busy = 0;
          m_idx = 0;
        end
      end else if (bus.clr_start) begin
        m_busy = 1;
        m_idx = 0;
      end
      exp_busy = m_busy;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("clr_busy", bus.clr_busy, exp_busy);
      check("wr_err", bus.wr_err, exp_wr_err);
      for (int p = 0; p < NR; p++) begin
        check($sformatf("rd_valid[%0d]", p), bus.rd_valid[p], exp_valid[p]);
        check($sformatf("rd_err[%0d]", p), bus.rd_err[p], exp_err[p]);
        if (exp_known[p]) check($sformatf("rd_data[%0d]", p), bus.rd_data[p*DW +: DW], exp_data[p]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr_start = 0;
    bus.wr_en = 0;
    bus.wr_row = '0;
    bus.wr_col = '0;
    bus.wr_data = '0;
    bus.rd_en = '0;
    bus.rd_row = '0;
    bus.rd_col = '0;
  endtask

  task automatic wr(int r, int c, int d);
    bus.wr_en = 1;
    bus.wr_row = RW'(r);
    bus.wr_col = CW'(c);
    bus.wr_data = DW'(d);
  endtask

  task automatic rd(int p, int r, int c);
    bus.rd_en[p] = 1;
    bus.rd_row[p*RW +: RW] = RW'(r);
    bus.rd_col[p*CW +: CW] = CW'(c);
  endtask

  function automatic logic [DW-1:0] pd(int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  task automatic fill(int seed);
    for (int i = 0; i < N; i++) begin
      idle();
      wr(i / COLS, i % COLS, int'(fd(i, seed)));
      tick();
    end
    idle();
  endtask

  task automatic read_all(bit zero);
    for (int i = 0; i < N; i += NR) begin
      idle();
      for (int p = 0; p < NR; p++) rd(p, (i + p) / COLS, (i + p) % COLS);
      tick();
      if (zero) for (int p = 0; p < NR; p++) check($sformatf("cleared[%0d]", i + p), pd(p), 0);
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk = 1;
    check("rst_clr_busy", bus.clr_busy, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    rst = 0;
    tick();

    wr(3, 5, 8'hA5); tick();
    idle(); rd(0, 3, 5); tick();
    check("t1_valid", bus.rd_valid[0], 1);
    check("t1_data", pd(0), 8'hA5);
    check("t1_err", bus.rd_err[0], 0);

    idle(); wr(2, 2, 8'h22); tick();
    idle(); wr(2, 2, 8'h11); rd(1, 2, 2); tick();
    check("t2_old", pd(1), 8'h22);
    idle(); rd(1, 2, 2); tick();
    check("t2_new", pd(1), 8'h11);

    idle(); wr(10, 0, 8'hFF); tick();
    check("t3_wr_err", bus.wr_err, 1);
    idle(); rd(0, 0, 6); tick();
    check("t3_valid", bus.rd_valid[0], 1);
    check("t3_err", bus.rd_err[0], 1);
    check("t3_data", pd(0), 0);
    idle(); rd(2, 2, 2); tick();
    check("t3_unchanged", pd(2), 8'h11);

    idle(); wr(0, 0, 8'h01); tick();
    wr(9, 5, 8'h02); tick();
    wr(5, 3, 8'h03); tick();
    idle(); rd(0, 0, 0); rd(1, 9, 5); rd(2, 5, 3); tick();
    check("t5_valid", bus.rd_valid, 3'b111);
    check("t5_d0", pd(0), 8'h01);
    check("t5_d1", pd(1), 8'h02);
    check("t5_d2", pd(2), 8'h03);

    fill(3);
    for (int k = 0; k < 600; k++) begin
      idle();
      if ($urandom_range(1, 0) == 1) wr($urandom_range(11, 0), $urandom_range(7, 0), $urandom_range(255, 0));
      bus.clr_start = ($urandom_range(99, 0) == 0);
      for (int p = 0; p < NR; p++)
        if ($urandom_range(1, 0) == 1) rd(p, $urandom_range(11, 0), $urandom_range(7, 0));
      tick();
    end
    idle();
    busy_cnt = 0;
    while (bus.clr_busy && busy_cnt < 100) begin
      busy_cnt++;
      tick();
    end
    check("drain_busy", bus.clr_busy, 0);

    fill(0);
    wr(4, 4, 8'h77);
    bus.clr_start = 1;
    tick();
    bus.clr_start = 0;
    wr(1, 1, 8'h33);
    busy_cnt = 0;
    while (bus.clr_busy && busy_cnt < 200) begin
      busy_cnt++;
      bus.clr_start = (busy_cnt == 10);
      tick();
    end
    idle();
    check("t4_busy_cycles", busy_cnt, N);
    tick();
    read_all(1);

    fill(7);
    bus.clr_start = 1;
    tick();
    bus.clr_start = 0;
    rd(0, 9, 5);
    wr(12, 0, 8'h5A);
    repeat (40) tick();
    check("t6_pre_valid", bus.rd_valid[0], 1);
    rst = 1;
    #1;
    check("t6_rst_busy", bus.clr_busy, 0);
    check("t6_rst_wr_err", bus.wr_err, 0);
    check("t6_rst_valid", bus.rd_valid, 0);
    check("t6_rst_data", bus.rd_data, 0);
    idle();
    @(posedge clk);
    #1;
    rst = 0;
    tick();
    rd(0, 6, 3); rd(1, 6, 4); tick();
    check("t6_idx39", pd(0), 0);
    check("t6_idx40", pd(1), fd(40, 7));
    read_all(0);

    tick();
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
